cnn_layer_sequencer: RTL

- Top-level controller for the inference pipeline. It sequences the conv, relu, pool and fc layers with per-stage enable/done handshakes, then scans the ten fc class scores serially to pick the winning digit.
- Replaces the free-running conv enable in the top level. Adds a per-stage watchdog, abort and a per-inference cycle counter.
- Sits between the top-level start/result interface and the layer modules.

---
 rtl/cnn_layer_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_layer_sequencer
//
// Top-level controller for the inference pipeline. It runs the conv, relu,
// pool and fc layers one after another using per-stage enable/done
// handshakes. It then scans the class scores one per cycle to pick the
// winning digit. Each stage has a watchdog, an abort input returns the
// sequencer to idle, and the latency of the last inference is recorded.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           begin an inference (accepted only when idle or in error)
//   abort           return to idle from any state
//   *_done          layer completion inputs (level or pulse)
//   prob_data       score of class prob_sel (external same-cycle mux)
//   prob_sel        class index being scanned (0 outside the scan)
//   *_enable        high while the matching stage is active
//   busy            high in every state except idle and error
//   result          winning class of the last completed inference
//   result_valid    one-cycle pulse when result updates
//   error           watchdog expired; sticky until start, abort or rst
//   err_stage       stage that timed out: 0 conv, 1 relu, 2 pool, 3 fc
//   last_latency    cycles from start acceptance to result_valid
// ---------------------------------------------------------------------------
module cnn_layer_sequencer #(
  parameter int PROB_W      = 32,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT     = 4096,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              conv_done,
  input  logic              relu_done,
  input  logic              pool_done,
  input  logic              fc_done,
  input  logic [PROB_W-1:0] prob_data,
  output logic [3:0]        prob_sel,
  output logic              conv_enable,
  output logic              relu_enable,
  output logic              pool_enable,
  output logic              fc_enable,
  output logic              busy,
  output logic [3:0]        result,
  output logic              result_valid,
  output logic              error,
  output logic [1:0]        err_stage,
  output logic [CNT_W-1:0]  last_latency
);

  localparam int               TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [3:0]       SEL_LAST = 4'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_RELU, S_POOL, S_FC, S_ARGMAX, S_DONE, S_ERR
  } state_t;

  state_t            state, state_n;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  cnt;
  logic [PROB_W-1:0] best_score;
  logic [3:0]        best_idx;
  logic              start_acc;
  logic              in_stage;
  logic              stage_done;
  logic              take;
  logic [1:0]        stage_code;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    in_stage   = 1'b0;
    stage_done = 1'b0;
    stage_code = 2'd0;
    case (state)
      S_CONV: begin in_stage = 1'b1; stage_done = conv_done; stage_code = 2'd0; end
      S_RELU: begin in_stage = 1'b1; stage_done = relu_done; stage_code = 2'd1; end
      S_POOL: begin in_stage = 1'b1; stage_done = pool_done; stage_code = 2'd2; end
      S_FC:   begin in_stage = 1'b1; stage_done = fc_done;   stage_code = 2'd3; end
      default: ;
    endcase

    start_acc = (state == S_IDLE || state == S_ERR) && start && !abort;

    // Index 0 always loads; later entries must be strictly greater so ties
    // keep the lower index.
    take = (prob_sel == 4'd0) || (prob_data > best_score);

    state_n = state;
    case (state)
      S_IDLE, S_ERR: if (start) state_n = S_CONV;
      S_CONV:   if (stage_done) state_n = S_RELU;   else if (timer == TMR_LAST) state_n = S_ERR;
      S_RELU:   if (stage_done) state_n = S_POOL;   else if (timer == TMR_LAST) state_n = S_ERR;
      S_POOL:   if (stage_done) state_n = S_FC;     else if (timer == TMR_LAST) state_n = S_ERR;
      S_FC:     if (stage_done) state_n = S_ARGMAX; else if (timer == TMR_LAST) state_n = S_ERR;
      S_ARGMAX: if (prob_sel == SEL_LAST) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    if (abort) state_n = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with the
  // state register: start accepted in cycle N shows conv_enable in N+1.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      cnt          <= '0;
      best_score   <= '0;
      best_idx     <= '0;
      prob_sel     <= '0;
      conv_enable  <= 1'b0;
      relu_enable  <= 1'b0;
      pool_enable  <= 1'b0;
      fc_enable    <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      err_stage    <= '0;
      last_latency <= '0;
    end else begin
      state        <= state_n;
      conv_enable  <= (state_n == S_CONV);
      relu_enable  <= (state_n == S_RELU);
      pool_enable  <= (state_n == S_POOL);
      fc_enable    <= (state_n == S_FC);
      busy         <= !(state_n == S_IDLE || state_n == S_ERR);
      result_valid <= (state_n == S_DONE);
      error        <= (state_n == S_ERR);

      if (state_n == S_ERR && state != S_ERR)
        err_stage <= stage_code;
      else if (state == S_ERR && state_n != S_ERR)
        err_stage <= '0;

      // Timer restarts on every stage entry and counts while the stage holds.
      timer <= (in_stage && state_n == state) ? timer + 1'b1 : '0;

      prob_sel <= (state == S_ARGMAX && state_n == S_ARGMAX) ? prob_sel + 4'd1 : 4'd0;

      if (state == S_ARGMAX && take) begin
        best_score <= prob_data;
        best_idx   <= prob_sel;
      end

      // cnt holds the busy cycles before the current one; adding 2 covers
      // the final scan cycle and the DONE cycle in which result_valid shows.
      if (state == S_ARGMAX && state_n == S_DONE) begin
        result       <= take ? prob_sel : best_idx;
        last_latency <= cnt + CNT_W'(2);
      end

      if (start_acc)
        cnt <= '0;
      else if (!(state == S_IDLE || state == S_ERR))
        cnt <= cnt + 1'b1;
    end
  end

endmodule
